// File: rtl/paddsb_pkg.sv
// Shared types and constants for the paddsb_seq saturating nibble add/sub unit.
package paddsb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIB_W = 4;

  localparam logic [NIB_W-1:0] SAT_POS = 4'b0111;
  localparam logic [NIB_W-1:0] SAT_NEG = 4'b1000;

endpackage

// File: rtl/paddsb_seq_nibble.sv
// Combinational 4-bit two's-complement saturating adder/subtractor.
module sat_nibble_addsub
  import paddsb_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  output logic [3:0] res,
  output logic       ovfl
);

  logic [3:0] bx;
  logic [3:0] low;   // {carry into bit3, sum bits 2..0}
  logic [1:0] top;   // {carry out of bit3, sum bit 3}

  always_comb begin
    bx   = b ^ {4{sub}};
    low  = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, sub};
    top  = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, low[3]};
    ovfl = low[3] ^ top[1];
    // Overflow is only possible when the effective operands share A's sign,
    // so A's sign selects the clamp direction for both add and subtract.
    if (ovfl) begin
      res = a[3] ? SAT_NEG : SAT_POS;
    end else begin
      res = {top[0], low[2:0]};
    end
  end

endmodule

// File: rtl/paddsb_seq.sv
// Sequential 16-bit per-nibble saturating add/sub with start/done handshake.
// Define PADDSB_PAIR_ISSUE_EN to process two nibbles per RUN cycle.
module paddsb_seq
  import paddsb_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NIB_W = paddsb_pkg::NIB_W
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic                     sub,
  output logic [WIDTH-1:0]         Sum,
  output logic [WIDTH/NIB_W-1:0]   Ovfl,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned NUM_NIB = WIDTH / NIB_W;
  localparam int unsigned IW      = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
`ifdef PADDSB_PAIR_ISSUE_EN
  localparam int unsigned STEP    = 2;
`else
  localparam int unsigned STEP    = 1;
`endif
  localparam logic [IW-1:0] LAST   = IW'(NUM_NIB - STEP);
  localparam logic [IW-1:0] STEP_V = IW'(STEP);

  state_t            state, state_n;
  logic [IW-1:0]     idx;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              sub_q;
  logic              accept;

  logic [NIB_W-1:0]  na0, nb0, nr0;
  logic              no0;

  always_comb begin
    na0 = a_q[idx*NIB_W +: NIB_W];
    nb0 = b_q[idx*NIB_W +: NIB_W];
  end

  sat_nibble_addsub u_nib0 (
    .a    (na0),
    .b    (nb0),
    .sub  (sub_q),
    .res  (nr0),
    .ovfl (no0)
  );

`ifdef PADDSB_PAIR_ISSUE_EN
  logic [IW-1:0]     idx1;
  logic [NIB_W-1:0]  na1, nb1, nr1;
  logic              no1;

  always_comb begin
    idx1 = idx + IW'(1);
    na1  = a_q[idx1*NIB_W +: NIB_W];
    nb1  = b_q[idx1*NIB_W +: NIB_W];
  end

  sat_nibble_addsub u_nib1 (
    .a    (na1),
    .b    (nb1),
    .sub  (sub_q),
    .res  (nr1),
    .ovfl (no1)
  );
`endif

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (idx == LAST) state_n = DONE;
      end
      DONE: begin
        if (start) begin
          state_n = RUN;
          accept  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == RUN);
      done  <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      Sum   <= '0;
      Ovfl  <= '0;
    end else if (accept) begin
      // Sum is left alone here; it is overwritten nibble by nibble in RUN.
      a_q   <= A;
      b_q   <= B;
      sub_q <= sub;
      Ovfl  <= '0;
      idx   <= '0;
    end else if (state == RUN) begin
      Sum[idx*NIB_W +: NIB_W] <= nr0;
      Ovfl[idx]               <= no0;
`ifdef PADDSB_PAIR_ISSUE_EN
      Sum[idx1*NIB_W +: NIB_W] <= nr1;
      Ovfl[idx1]               <= no1;
`endif
      idx <= idx + STEP_V;
    end
  end

endmodule

// File: tb/tb_paddsb_seq.sv
// Self-checking bench for paddsb_seq: vector table, scoreboard, handshake corners.
module tb_paddsb_seq;

`ifdef PADDSB_PAIR_ISSUE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        sub = 1'b0;
  logic [15:0] Sum;
  logic [3:0]  Ovfl;
  logic        busy;
  logic        done;

  paddsb_seq #(.WIDTH(16), .NIB_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .sub   (sub),
    .Sum   (Sum),
    .Ovfl  (Ovfl),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] sum;
    logic [3:0]  ov;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic [3:0]  ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_push = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] s, input logic [3:0] o);
    exp_t e;
    e.sum = s;
    e.ov  = o;
    exp_q.push_back(e);
    n_push++;
  endtask

  // Reference: signed integer arithmetic clamped to the 4-bit range.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] r, output logic [3:0] o);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] an, bn;
      int av, bv, t;
      an = a[i*4 +: 4];
      bn = b[i*4 +: 4];
      av = int'(an); if (av > 7) av -= 16;
      bv = int'(bn); if (bv > 7) bv -= 16;
      t  = s ? av - bv : av + bv;
      o[i] = 1'b0;
      if (t > 7)  begin t = 7;  o[i] = 1'b1; end
      if (t < -8) begin t = -8; o[i] = 1'b1; end
      r[i*4 +: 4] = 4'(t);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #2;
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", {16'h0, Sum}, {16'h0, e.sum});
        check("ovfl", {28'h0, Ovfl}, {28'h0, e.ov});
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] es, input logic [3:0] eo, input bit glitch);
    A = a; B = b; sub = s; start = 1'b1;
    push_exp(es, eo);
    tick();
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); sub = ~s;
    for (int k = 1; k <= LAT; k++) begin
      check("busy_run", {31'h0, busy}, 32'd1);
      check("done_run", {31'h0, done}, 32'd0);
      if (glitch && k == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("busy_done", {31'h0, busy}, 32'd0);
    check("done_pulse", {31'h0, done}, 32'd1);
    tick();
    check("done_once", {31'h0, done}, 32'd0);
    check("busy_idle", {31'h0, busy}, 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    logic [15:0] rs, ra, rb;
    logic [3:0]  ro;
    logic        rsub;

    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 4'b0000};
    tbl[1] = '{16'h7F81, 16'h1181, 1'b0, 16'h7082, 4'b1010};
    tbl[2] = '{16'h8000, 16'h1000, 1'b1, 16'h8000, 4'b1000};
    tbl[3] = '{16'h0123, 16'h0123, 1'b1, 16'h0000, 4'b0000};
    tbl[4] = '{16'h7777, 16'h1111, 1'b0, 16'h7777, 4'b1111};
    tbl[5] = '{16'h8888, 16'h1111, 1'b1, 16'h8888, 4'b1111};

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_sum",  {16'h0, Sum},  32'd0);
    check("rst_ovfl", {28'h0, Ovfl}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].sum, tbl[i].ov, 1'b0);

    // start pulsed during RUN must be ignored
    run_op(tbl[0].a, tbl[0].b, tbl[0].s, tbl[0].sum, tbl[0].ov, 1'b1);
    tick();
    check("glitch_no_rerun", {31'h0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rsub = 1'($urandom);
      model(ra, rb, rsub, rs, ro);
      run_op(ra, rb, rsub, rs, ro, 1'b0);
    end

    // reset mid-op: no done pulse, outputs cleared
    A = tbl[1].a; B = tbl[1].b; sub = tbl[1].s; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("midrst_sum",  {16'h0, Sum},  32'd0);
    check("midrst_ovfl", {28'h0, Ovfl}, 32'd0);
    check("midrst_busy", {31'h0, busy}, 32'd0);
    check("midrst_done", {31'h0, done}, 32'd0);
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      check("midrst_quiet", {30'h0, busy, done}, 32'd0);
    end

    // back-to-back with start held through DONE
    A = tbl[1].a; B = tbl[1].b; sub = tbl[1].s; start = 1'b1;
    push_exp(tbl[1].sum, tbl[1].ov);
    push_exp(tbl[2].sum, tbl[2].ov);
    tick();
    A = tbl[2].a; B = tbl[2].b; sub = tbl[2].s;
    for (int op = 0; op < 2; op++) begin
      for (int k = 1; k <= LAT; k++) begin
        check("b2b_busy", {31'h0, busy}, 32'd1);
        check("b2b_done", {31'h0, done}, 32'd0);
        tick();
      end
      check("b2b_pulse", {31'h0, done}, 32'd1);
      check("b2b_busy_done", {31'h0, busy}, 32'd0);
      tick();
      start = 1'b0;
      A = 16'($urandom); B = 16'($urandom);
    end
    check("b2b_idle", {30'h0, busy, done}, 32'd0);

    tick(); tick();
    check("queue_drained", exp_q.size(), 32'd0);
    check("done_count", n_done, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
